div_rr_scheduler: RTL and testbench

//  Shares one pipelined integer divider (valid/ready, DIV_LAT-cycle latency) among NUM_REQ requesters.

---
 rtl/div_rr_scheduler_pkg.sv | 19 +
 rtl/div_rr_scheduler_rr_arbiter.sv | 51 +++++
 rtl/div_rr_scheduler.sv | 123 ++++++++++++
 tb/tb_div_rr_scheduler.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_rr_scheduler_pkg.sv
// Shared types for the divider scheduler: operand width, requester id and
// the tag that travels alongside each divide in flight.
package div_rr_scheduler_pkg;

  localparam int INT_W    = 32;
  // Tags carry ids for up to MAX_REQ requesters; NUM_REQ must not exceed it.
  localparam int MAX_REQ  = 16;
  localparam int REQ_ID_W = $clog2(MAX_REQ);

  typedef logic [INT_W-1:0]    int_t;
  typedef logic [REQ_ID_W-1:0] req_id_t;

  typedef struct packed {
    logic    vld;
    req_id_t id;
    logic    dz;
  } div_tag_t;

endpackage

// File: rtl/div_rr_scheduler_rr_arbiter.sv
// Round-robin arbiter: scans upward from the pointer with wrap-around and
// moves the pointer just past the winner whenever a grant is taken.
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               en_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [ID_W-1:0]    grant_id_o,
  output logic               any_o
);

  logic [ID_W-1:0] ptr_q, ptr_d;
  logic            found;

  // First pass covers ptr..NUM_REQ-1, second pass wraps around to 0..ptr-1.
  always_comb begin
    grant_o    = '0;
    grant_id_o = '0;
    found      = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req_i[i] && i >= int'(ptr_q)) begin
        grant_o[i] = 1'b1;
        grant_id_o = ID_W'(i);
        found      = 1'b1;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req_i[i]) begin
        grant_o[i] = 1'b1;
        grant_id_o = ID_W'(i);
        found      = 1'b1;
      end
    end
  end

  assign any_o = found;
  assign ptr_d = (grant_id_o == ID_W'(NUM_REQ - 1)) ? '0 : grant_id_o + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (en_i && found) begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/div_rr_scheduler.sv
// Shares one pipelined divider among NUM_REQ requesters; a tag pipe shadows
// the divider so each quotient is steered back to the requester that issued it.
module div_rr_scheduler
  import div_rr_scheduler_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DIV_LAT = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req_vld,
  output logic [NUM_REQ-1:0] req_rdy,
  input  int_t [NUM_REQ-1:0] req_num,
  input  int_t [NUM_REQ-1:0] req_den,
  output logic [NUM_REQ-1:0] rsp_vld,
  input  logic [NUM_REQ-1:0] rsp_rdy,
  output int_t               rsp_quot,
  output logic               rsp_dz,
  output logic               div_vld_in,
  output logic               div_rdy_in,
  input  logic               div_rdy_out,
  input  logic               div_vld_out,
  output int_t               div_num,
  output int_t               div_den,
  input  int_t               div_quot,
  output logic [31:0]        busy_cnt
);

  localparam int LAST = DIV_LAT - 1;
  localparam int ID_W = $clog2(NUM_REQ);

  div_tag_t [DIV_LAT-1:0] tag_q;
  div_tag_t               stage0_d;
  logic [31:0]            busy_q, busy_d;
  logic                   adv, ownerRdy, issue, arbEn, anyReq, anyBusy;
  logic [NUM_REQ-1:0]     grant;
  logic [ID_W-1:0]        grantId;

  // The tail tag names the owner of the quotient currently at the divider output.
  always_comb begin
    rsp_vld  = '0;
    ownerRdy = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (tag_q[LAST].vld && tag_q[LAST].id == req_id_t'(i)) begin
        rsp_vld[i] = !rst;
        ownerRdy   = rsp_rdy[i];
      end
    end
  end

  assign adv        = rst || !tag_q[LAST].vld || ownerRdy;
  assign div_rdy_in = adv;
  assign rsp_quot   = div_quot;
  assign rsp_dz     = !rst && tag_q[LAST].vld && tag_q[LAST].dz;

  // Issue also waits on adv so a tag can never be dropped into a frozen pipe.
  assign arbEn      = !rst && div_rdy_out && adv;
  assign issue      = arbEn && anyReq;
  assign div_vld_in = issue;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req_i     (req_vld),
    .en_i      (arbEn),
    .grant_o   (grant),
    .grant_id_o(grantId),
    .any_o     (anyReq)
  );

  always_comb begin
    req_rdy  = '0;
    div_num  = '0;
    div_den  = '0;
    stage0_d = '0;
    if (issue) begin
      req_rdy = grant;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant[i]) begin
          div_num = req_num[i];
          div_den = req_den[i];
        end
      end
      stage0_d.vld = 1'b1;
      stage0_d.id  = req_id_t'(grantId);
      stage0_d.dz  = (div_den == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_q <= '0;
    end else if (adv) begin
      tag_q[0] <= stage0_d;
      for (int s = 1; s < DIV_LAT; s++) begin
        tag_q[s] <= tag_q[s-1];
      end
    end
  end

  always_comb begin
    anyBusy = 1'b0;
    for (int s = 0; s < DIV_LAT; s++) begin
      anyBusy = anyBusy | tag_q[s].vld;
    end
  end

  assign busy_d = (anyBusy && busy_q != '1) ? busy_q + 32'd1 : busy_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_cnt = busy_q;

  assert property (@(posedge clk) disable iff (rst) div_vld_out == tag_q[LAST].vld);
  assert property (@(posedge clk) disable iff (rst) $onehot0(rsp_vld));

endmodule

// File: tb/tb_div_rr_scheduler.sv
// Bench for div_rr_scheduler with a one-cycle divider attached; a queue-based
// reference model predicts grants, responses and the busy count every cycle.
module tb_div_rr_scheduler;
  import div_rr_scheduler_pkg::*;

  localparam int NR = 4;
  localparam int DL = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [NR-1:0] req_vld, req_rdy, rsp_vld, rsp_rdy;
  int_t [NR-1:0] req_num, req_den;
  int_t          rsp_quot, div_num, div_den, div_quot;
  logic          rsp_dz, div_vld_in, div_rdy_in, div_rdy_out, div_vld_out;
  logic [31:0]   busy_cnt;

  always #5 clk = ~clk;

  div_rr_scheduler #(.NUM_REQ(NR), .DIV_LAT(DL)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_vld    (req_vld),
    .req_rdy    (req_rdy),
    .req_num    (req_num),
    .req_den    (req_den),
    .rsp_vld    (rsp_vld),
    .rsp_rdy    (rsp_rdy),
    .rsp_quot   (rsp_quot),
    .rsp_dz     (rsp_dz),
    .div_vld_in (div_vld_in),
    .div_rdy_in (div_rdy_in),
    .div_rdy_out(div_rdy_out),
    .div_vld_out(div_vld_out),
    .div_num    (div_num),
    .div_den    (div_den),
    .div_quot   (div_quot),
    .busy_cnt   (busy_cnt)
  );

  // Single-stage divider that freezes while rdy_in is low.
  logic dvVld;
  int_t dvQuot;
  always @(posedge clk) begin
    if (rst) begin
      dvVld  <= 1'b0;
      dvQuot <= '0;
    end else if (div_rdy_in) begin
      dvVld  <= div_vld_in;
      dvQuot <= (div_den == '0) ? '0 : div_num / div_den;
    end
  end
  assign div_vld_out = dvVld;
  assign div_quot    = dvQuot;
  assign div_rdy_out = div_rdy_in;

  typedef struct {
    int   id;
    int_t quot;
    bit   dz;
  } op_t;

  op_t     inflight[$];
  int      ptrM = 0;
  longint  busyM = 0;
  int      expG;
  bit      expIssue, expStall;
  int_t    expNum, expDen;
  int      compared = 0;
  int      mismatched = 0;

  task automatic checkEq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [NR-1:0] v, input logic [NR-1:0] r);
    req_vld = v;
    rsp_rdy = r;
  endtask

  task automatic setOp(input int i, input int_t n, input int_t d);
    req_num[i] = n;
    req_den[i] = d;
  endtask

  task automatic checkOutput(input string tag);
    logic [NR-1:0] eRsp, eRdy;
    int_t          eNum, eDen;
    expStall = 1'b0;
    expIssue = 1'b0;
    expG     = 0;
    eRsp     = '0;
    eRdy     = '0;
    eNum     = '0;
    eDen     = '0;
    if (!rst) begin
      if (inflight.size() > 0) begin
        eRsp[inflight[0].id] = 1'b1;
        expStall = !rsp_rdy[inflight[0].id];
      end
      if (!expStall && req_vld != '0) begin
        for (int k = 0; k < NR; k++) begin
          if (req_vld[(ptrM + k) % NR]) begin
            expG = (ptrM + k) % NR;
            break;
          end
        end
        expIssue   = 1'b1;
        eRdy[expG] = 1'b1;
        eNum       = req_num[expG];
        eDen       = req_den[expG];
      end
    end
    expNum = eNum;
    expDen = eDen;
    checkEq({tag, ".req_rdy"}, req_rdy, eRdy);
    checkEq({tag, ".rsp_vld"}, rsp_vld, eRsp);
    checkEq({tag, ".div_vld_in"}, div_vld_in, expIssue);
    checkEq({tag, ".div_rdy_in"}, div_rdy_in, !expStall);
    checkEq({tag, ".div_num"}, div_num, eNum);
    checkEq({tag, ".div_den"}, div_den, eDen);
    checkEq({tag, ".busy_cnt"}, busy_cnt, busyM);
    if (rst) begin
      checkEq({tag, ".rsp_dz"}, rsp_dz, 0);
    end else if (inflight.size() > 0) begin
      checkEq({tag, ".rsp_quot"}, rsp_quot, inflight[0].quot);
      checkEq({tag, ".rsp_dz"}, rsp_dz, inflight[0].dz);
    end
  endtask

  task automatic sampleAndCheck(input string tag);
    @(negedge clk);
    checkOutput(tag);
  endtask

  task automatic advance();
    op_t op;
    @(posedge clk);
    if (rst) begin
      inflight.delete();
      ptrM  = 0;
      busyM = 0;
    end else begin
      if (inflight.size() > 0 && busyM < 64'hFFFF_FFFF) busyM++;
      if (!expStall) begin
        if (inflight.size() > 0) void'(inflight.pop_front());
        if (expIssue) begin
          op.id   = expG;
          op.dz   = (expDen == '0);
          op.quot = op.dz ? '0 : expNum / expDen;
          inflight.push_back(op);
          ptrM = (expG + 1) % NR;
        end
      end
    end
    #1;
  endtask

  task automatic resetDut();
    rst = 1'b1;
    applyStimulus('0, '1);
    sampleAndCheck("reset");
    advance();
    sampleAndCheck("reset");
    advance();
    rst = 1'b0;
  endtask

  initial begin
    int   waitCnt;
    bit   seen2;
    int_t nums[NR];
    int_t dens[NR];
    rst     = 1'b1;
    req_vld = '0;
    rsp_rdy = '1;
    req_num = '0;
    req_den = '0;

    resetDut();
    checkEq("rst.busy_cnt", busy_cnt, 0);
    checkEq("rst.div_rdy_in", div_rdy_in, 1);

    // Single op 100/7 to requester 0.
    setOp(0, 100, 7);
    applyStimulus(4'b0001, 4'b1111);
    sampleAndCheck("t1.issue");
    checkEq("t1.req_rdy", req_rdy, 4'b0001);
    advance();
    applyStimulus(4'b0000, 4'b1111);
    sampleAndCheck("t1.rsp");
    checkEq("t1.rsp_vld", rsp_vld, 4'b0001);
    checkEq("t1.rsp_quot", rsp_quot, 14);
    checkEq("t1.rsp_dz", rsp_dz, 0);
    advance();

    // All four valid every cycle.
    resetDut();
    nums = '{12, 20, 30, 42};
    dens = '{3, 4, 5, 6};
    for (int i = 0; i < NR; i++) setOp(i, nums[i], dens[i]);
    for (int c = 0; c < 8; c++) begin
      applyStimulus(4'b1111, 4'b1111);
      sampleAndCheck("t2.stream");
      checkEq("t2.grant", req_rdy, 4'b0001 << (c % NR));
      if (c > 0) checkEq("t2.quot", rsp_quot, 4 + (c - 1) % NR);
      advance();
    end
    applyStimulus(4'b0000, 4'b1111);
    sampleAndCheck("t2.drain");
    checkEq("t2.last_rsp", rsp_vld, 4'b1000);
    advance();

    // Backpressure on requester 1 with requester 2 pending.
    setOp(1, 9, 3);
    setOp(2, 28, 7);
    applyStimulus(4'b0010, 4'b1111);
    sampleAndCheck("t3.issue");
    advance();
    for (int c = 0; c < 3; c++) begin
      applyStimulus(4'b0100, 4'b1101);
      sampleAndCheck("t3.stall");
      checkEq("t3.hold_vld", rsp_vld, 4'b0010);
      checkEq("t3.hold_quot", rsp_quot, 3);
      checkEq("t3.no_rdy", req_rdy, 4'b0000);
      advance();
    end
    applyStimulus(4'b0100, 4'b1111);
    sampleAndCheck("t3.release");
    checkEq("t3.issue_same_cycle", req_rdy, 4'b0100);
    advance();
    applyStimulus(4'b0000, 4'b1111);
    sampleAndCheck("t3.rsp2");
    checkEq("t3.rsp2_quot", rsp_quot, 4);
    advance();

    // Divide by zero on requester 3.
    setOp(3, 55, 0);
    applyStimulus(4'b1000, 4'b1111);
    sampleAndCheck("t4.issue");
    advance();
    applyStimulus(4'b0000, 4'b1111);
    sampleAndCheck("t4.rsp");
    checkEq("t4.rsp_vld", rsp_vld, 4'b1000);
    checkEq("t4.rsp_quot", rsp_quot, 0);
    checkEq("t4.rsp_dz", rsp_dz, 1);
    advance();

    // Reset while an op is in flight.
    setOp(0, 8, 2);
    applyStimulus(4'b0001, 4'b1111);
    sampleAndCheck("t5.issue");
    advance();
    resetDut();
    for (int c = 0; c < 2; c++) begin
      applyStimulus(4'b0000, 4'b1111);
      sampleAndCheck("t5.quiet");
      checkEq("t5.no_rsp", rsp_vld, 4'b0000);
      checkEq("t5.busy_cnt", busy_cnt, 0);
      advance();
    end
    applyStimulus(4'b1111, 4'b1111);
    sampleAndCheck("t5.ptr");
    checkEq("t5.ptr_zero", req_rdy, 4'b0001);
    advance();
    applyStimulus(4'b0000, 4'b1111);
    sampleAndCheck("t5.drain");
    advance();

    // Fairness: requester 0 always valid, requester 2 joins at cycle 5.
    resetDut();
    setOp(0, 77, 7);
    setOp(2, 64, 8);
    waitCnt = 0;
    seen2   = 1'b0;
    for (int c = 0; c < 12; c++) begin
      applyStimulus((c >= 5) ? 4'b0101 : 4'b0001, 4'b1111);
      sampleAndCheck("t6.run");
      if (c >= 5 && !seen2) begin
        if (req_rdy[2]) seen2 = 1'b1;
        else waitCnt++;
      end
      advance();
    end
    checkEq("t6.fair", (seen2 && waitCnt < NR), 1);
    applyStimulus(4'b0000, 4'b1111);
    sampleAndCheck("t6.drain");
    advance();
    sampleAndCheck("t6.busy");
    checkEq("t6.busy_cnt", busy_cnt, 12);
    advance();

    // Random traffic with random backpressure and occasional resets.
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      for (int i = 0; i < NR; i++) begin
        setOp(i, $urandom, $urandom_range(0, 15));
      end
      applyStimulus(NR'($urandom), {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
                                    ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)});
      sampleAndCheck("rand");
      advance();
    end
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
